// File: rtl/gcd_master_rr.sv
// Multi-channel GCD request master: per-channel job slots, round-robin arbitration
// onto one shared req/busy/valid GCD engine, local zero-operand resolution and a WAIT watchdog.
module gcd_master_rr #(
    parameter int WIDTH   = 4,
    parameter int NUM_CH  = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_CH-1:0]         in_valid_i,
    output logic [NUM_CH-1:0]         in_ready_o,
    input  logic [NUM_CH*WIDTH-1:0]   op_a_i,
    input  logic [NUM_CH*WIDTH-1:0]   op_b_i,
    output logic [NUM_CH-1:0]         res_valid_o,
    input  logic [NUM_CH-1:0]         res_ready_i,
    output logic [NUM_CH*WIDTH-1:0]   res_data_o,
    output logic [NUM_CH-1:0]         res_err_o,
    output logic                      req_o,
    output logic [WIDTH-1:0]          a_o,
    output logic [WIDTH-1:0]          b_o,
    input  logic                      busy_i,
    input  logic                      valid_i,
    input  logic [WIDTH-1:0]          result_val_i
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);

    localparam logic [1:0] FSM_IDLE  = 2'd0;
    localparam logic [1:0] FSM_ISSUE = 2'd1;
    localparam logic [1:0] FSM_WAIT  = 2'd2;

    localparam logic [1:0] SLOT_EMPTY = 2'd0;
    localparam logic [1:0] SLOT_PEND  = 2'd1;
    localparam logic [1:0] SLOT_DONE  = 2'd2;

    logic [1:0]                    fsm_q, fsm_d;
    logic [CH_W-1:0]               ptr_q, ptr_d;
    logic [CH_W-1:0]               gnt_q, gnt_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [NUM_CH-1:0][1:0]        slot_q, slot_d;
    logic [NUM_CH-1:0][WIDTH-1:0]  opa_q, opa_d;
    logic [NUM_CH-1:0][WIDTH-1:0]  opb_q, opb_d;
    logic [NUM_CH-1:0][WIDTH-1:0]  res_q, res_d;
    logic [NUM_CH-1:0]             err_q, err_d;

    logic                          arb_hit_s;
    logic [CH_W-1:0]               arb_ch_s;
    logic [CH_W-1:0]               arb_next_s;
    logic [CH_W:0]                 arb_sum_s;

    // Round-robin pick: scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        arb_hit_s = 1'b0;
        arb_ch_s  = '0;
        arb_sum_s = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            arb_sum_s = {1'b0, ptr_q} + (CH_W+1)'(i);
            arb_sum_s = (arb_sum_s >= (CH_W+1)'(NUM_CH)) ? arb_sum_s - (CH_W+1)'(NUM_CH) : arb_sum_s;
            arb_ch_s  = (slot_q[arb_sum_s[CH_W-1:0]] == SLOT_PEND) ? arb_sum_s[CH_W-1:0] : arb_ch_s;
            arb_hit_s = arb_hit_s | (slot_q[arb_sum_s[CH_W-1:0]] == SLOT_PEND);
        end
        arb_next_s = (arb_ch_s == CH_W'(NUM_CH - 1)) ? '0 : arb_ch_s + CH_W'(1);
    end

    // Slot handshakes and engine-sequencing FSM next state.
    always_comb begin
        fsm_d  = fsm_q;
        ptr_d  = ptr_q;
        gnt_d  = gnt_q;
        cnt_d  = cnt_q;
        slot_d = slot_q;
        opa_d  = opa_q;
        opb_d  = opb_q;
        res_d  = res_q;
        err_d  = err_q;

        for (int c = 0; c < NUM_CH; c++) begin
            if (slot_q[c] == SLOT_EMPTY && in_valid_i[c]) begin
                slot_d[c] = SLOT_PEND;
                opa_d[c]  = op_a_i[c*WIDTH +: WIDTH];
                opb_d[c]  = op_b_i[c*WIDTH +: WIDTH];
            end else if (slot_q[c] == SLOT_DONE && res_ready_i[c]) begin
                slot_d[c] = SLOT_EMPTY;
            end else begin
                slot_d[c] = slot_q[c];
            end
        end

        case (fsm_q)
            FSM_IDLE: begin
                if (arb_hit_s) begin
                    ptr_d = arb_next_s;
                    // gcd(0,x)=x and gcd(0,0)=0, so a|b is the answer without the engine
                    if (opa_q[arb_ch_s] == '0 || opb_q[arb_ch_s] == '0) begin
                        slot_d[arb_ch_s] = SLOT_DONE;
                        res_d[arb_ch_s]  = opa_q[arb_ch_s] | opb_q[arb_ch_s];
                        err_d[arb_ch_s]  = 1'b0;
                    end else begin
                        fsm_d = FSM_ISSUE;
                        gnt_d = arb_ch_s;
                    end
                end else begin
                    fsm_d = FSM_IDLE;
                end
            end
            FSM_ISSUE: begin
                if (valid_i) begin
                    slot_d[gnt_q] = SLOT_DONE;
                    res_d[gnt_q]  = result_val_i;
                    err_d[gnt_q]  = 1'b0;
                    fsm_d         = FSM_IDLE;
                end else if (busy_i) begin
                    fsm_d = FSM_WAIT;
                    cnt_d = '0;
                end else begin
                    fsm_d = FSM_ISSUE;
                end
            end
            FSM_WAIT: begin
                if (valid_i) begin
                    slot_d[gnt_q] = SLOT_DONE;
                    res_d[gnt_q]  = result_val_i;
                    err_d[gnt_q]  = 1'b0;
                    fsm_d         = FSM_IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    slot_d[gnt_q] = SLOT_DONE;
                    res_d[gnt_q]  = '0;
                    err_d[gnt_q]  = 1'b1;
                    fsm_d         = FSM_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                fsm_d = FSM_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fsm_q  <= FSM_IDLE;
            ptr_q  <= '0;
            gnt_q  <= '0;
            cnt_q  <= '0;
            slot_q <= '0;
            opa_q  <= '0;
            opb_q  <= '0;
            res_q  <= '0;
            err_q  <= '0;
        end else begin
            fsm_q  <= fsm_d;
            ptr_q  <= ptr_d;
            gnt_q  <= gnt_d;
            cnt_q  <= cnt_d;
            slot_q <= slot_d;
            opa_q  <= opa_d;
            opb_q  <= opb_d;
            res_q  <= res_d;
            err_q  <= err_d;
        end
    end

    // Per-channel status decoded straight from the slot registers.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            in_ready_o[c]  = (slot_q[c] == SLOT_EMPTY);
            res_valid_o[c] = (slot_q[c] == SLOT_DONE);
        end
    end

    assign res_data_o = res_q;
    assign res_err_o  = err_q;
    assign req_o      = (fsm_q == FSM_ISSUE);
    assign a_o        = (fsm_q == FSM_ISSUE) ? opa_q[gnt_q] : '0;
    assign b_o        = (fsm_q == FSM_ISSUE) ? opb_q[gnt_q] : '0;

endmodule
